seq_det_param: RTL and testbench
================================

# seq_det_param

Parametrised serial sequence detector, the successor to the fixed-pattern `seq_det`. It samples a 1-bit serial stream under a valid qualifier and compares it against a runtime-loadable pattern of 1..MAX_LEN bits. Detection runs in overlapping or non-overlapping mode, and each hit is counted in a saturating match counter. It sits directly on serial input lanes as a framing and sync-word detector.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2); LEN_W = $clog2(MAX_LEN)+1
- CNT_W, 8, match counter width
- RST_PATTERN, 8'b0000_1011, pattern loaded at reset (low MAX_LEN bits used)
- RST_LEN, 4, pattern length loaded at reset
- RST_OVERLAP, 1, overlap mode loaded at reset
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  `in` is sampled on this edge
- in  in  1  serial data bit
- cfg_load  in  1  latch cfg_* on this edge
- cfg_pattern  in  MAX_LEN  pattern; bit len-1 = first bit received, bit 0 = last
- cfg_len  in  LEN_W  pattern length; 0 clamps to 1, >MAX_LEN clamps to MAX_LEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of match_cnt
- out  out  1  one-cycle registered match pulse
- match_cnt  out  CNT_W  saturating count of matches
- armed  out  1  history holds ≥ len valid bits since the last flush

## Operation
- State registers:
  - hist[MAX_LEN-1:0] shift register
  - fill[LEN_W-1:0] count of valid bits since the last flush, saturating at MAX_LEN
  - pat, len, ovl configuration registers
- Fill states, derived from fill:
  - EMPTY (fill=0)
  - FILLING (0<fill<len)
  - ARMED (fill≥len)
- Accepted bit (in_valid=1, cfg_load=0):
  - hist ← {hist[MAX_LEN-2:0], in}
  - fill ← min(fill+1, MAX_LEN)
- Match condition, evaluated on the new values: new fill ≥ len and new hist[len-1:0] == pat[len-1:0]. Bits above len-1 are ignored.
- On a match:
  - out ← 1 and match_cnt increments, saturating at 2^CNT_W−1
  - ovl=1: fill keeps its updated value
  - ovl=0: fill ← 0 (flush), so the next match needs len fresh bits
- in_valid=0: hist and fill hold, out ← 0
- cfg_load=1:
  - pat, len (clamped) and ovl latch
  - hist ← 0, fill ← 0, out ← 0
  - in_valid is ignored on that edge
  - match_cnt is unaffected
- cnt_clr=1: match_cnt ← 0. Clear wins over a simultaneous increment; out still pulses.
- armed = (fill ≥ len), combinational from registers.

## Timing
- Reset (rst=0, asynchronous):
  - hist=0, fill=0, out=0, match_cnt=0, armed=0
  - pat=RST_PATTERN, len=RST_LEN, ovl=RST_OVERLAP
  - Release is synchronous to clk; the first edge with rst=1 may accept a bit.
- Latency: out rises at the same edge that samples the completing bit and is high for exactly that one cycle. match_cnt updates on that same edge.
- Back-to-back: in overlap mode with len=1, out can be high on consecutive cycles.
- Reset mid-stream discards partial history. Bits sampled before reset never contribute to a match.
- Configuration is not double-buffered; it takes effect for the bit accepted on the edge after cfg_load.

## Test plan
- Reset defaults (1011, overlap), stream 1,0,1,1,0,1,1 on consecutive valid cycles -> out pulses after bits 4 and 7, match_cnt=2, armed=1 from bit 4 onward.
- cfg_load pattern=0110, len=4, overlap=0, stream 0,1,1,0,1,1,0 -> single pulse after bit 4 (overlap would also hit at bit 7), match_cnt=1, armed=0 after the match.
- Default config, stream 1,0,1,1 with in_valid=0 for 2 cycles between each bit -> one pulse, only on the edge sampling bit 4; out=0 on all idle cycles.
- Stream 1,0,1, then cfg_load len=3 pattern=101, then bits 1,0,1 -> no pulse after the first post-load bit, pulse after the third, match_cnt=1; load edge bit ignored.
- CNT_W=2, len=1 pattern=1 overlap, five consecutive 1s -> out high 5 cycles, match_cnt saturates at 3; cnt_clr on the 6th edge with a match -> match_cnt=0, out=1.
- Stream 1,0,1, assert rst=0 mid-cycle for 1 cycle, then 1 -> outputs clear immediately, no pulse on the following bit; cfg_len=0 and cfg_len=15 (MAX_LEN=8) clamp to 1 and 8.

Source files
------------

// File: rtl/seq_det_param.sv
// seq_det_param: serial sequence detector with a runtime-loadable pattern
// of 1..MAX_LEN bits. It supports overlapping and non-overlapping detection
// and keeps a saturating count of matches.
module seq_det_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
    localparam int               RST_LEN_CI = (RST_LEN < 1) ? 1 :
                                              (RST_LEN > MAX_LEN) ? MAX_LEN : RST_LEN;
    localparam logic [LEN_W-1:0] RST_LEN_C  = LEN_W'(RST_LEN_CI);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        ARMED
    } fill_state_t;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_acc;
    logic [LEN_W-1:0]   fill_acc;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic [LEN_W-1:0]   len_clamped;
    fill_state_t        fill_state;

    // State register: history, fill count, configuration, match pulse and counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= RST_PATTERN;
            len_q  <= RST_LEN_C;
            ovl_q  <= RST_OVERLAP;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next state: a config load flushes history; otherwise a valid bit shifts in
    // and is checked against the low len bits of the pattern
    always_comb begin
        hist_d      = hist_q;
        fill_d      = fill_q;
        pat_d       = pat_q;
        len_d       = len_q;
        ovl_d       = ovl_q;
        out_d       = 1'b0;
        cnt_d       = cnt_q;
        len_mask    = '0;

        hist_acc = {hist_q[MAX_LEN-2:0], in};
        fill_acc = (fill_q >= MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        hit = (fill_acc >= len_q) && (((hist_acc ^ pat_q) & len_mask) == '0);

        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > MAX_LEN_L) begin
            len_clamped = MAX_LEN_L;
        end else begin
            len_clamped = cfg_len;
        end

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = len_clamped;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_acc;
            fill_d = (hit && !ovl_q) ? '0 : fill_acc;
            out_d  = hit;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs: classify the fill level and drive the registered results
    always_comb begin
        if (fill_q == '0) begin
            fill_state = EMPTY;
        end else if (fill_q < len_q) begin
            fill_state = FILLING;
        end else begin
            fill_state = ARMED;
        end
        armed     = (fill_state == ARMED);
        out       = out_q;
        match_cnt = cnt_q;
    end

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed tests for seq_det_param. The counter is built
// narrow so that saturation can be reached with a short stream.
module tb_seq_det_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;

    int errors = 0;
    int checks = 0;

    seq_det_param #(
        .MAX_LEN     (MAX_LEN),
        .LEN_W       (LEN_W),
        .CNT_W       (CNT_W),
        .RST_PATTERN (8'b0000_1011),
        .RST_LEN     (4),
        .RST_OVERLAP (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in          (in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .match_cnt   (match_cnt),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of serial input, then sample just after the edge
    task automatic put_bit(input logic v, input logic b);
        in_valid = v;
        in       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in       = 1'b0;
    endtask

    // Load a configuration on the next edge, optionally with a bit and a clear present
    task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                            input logic o, input logic v, input logic b, input logic clr);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        in_valid    = v;
        in          = b;
        cnt_clr     = clr;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        in       = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    // Pulse reset away from the clock edge
    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out got=%b want=0", out);
        end
        checks++;
        if (match_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt got=%0d want=0", match_cnt);
        end
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_armed got=%b want=0", armed);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overlap_default();
        logic [6:0] stream  = 7'b1011011;
        logic [6:0] exp_out = 7'b0001001;
        logic [6:0] exp_arm = 7'b0001111;
        for (int i = 0; i < 7; i++) begin
            put_bit(1'b1, stream[6-i]);
            checks++;
            if (out !== exp_out[6-i]) begin
                errors++;
                $display("[TB] FAIL ovl_out bit%0d got=%b want=%b", i + 1, out, exp_out[6-i]);
            end
            checks++;
            if (armed !== exp_arm[6-i]) begin
                errors++;
                $display("[TB] FAIL ovl_armed bit%0d got=%b want=%b", i + 1, armed, exp_arm[6-i]);
            end
        end
        checks++;
        if (match_cnt !== 2'd2) begin
            errors++;
            $display("[TB] FAIL ovl_cnt got=%0d want=2", match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] stream  = 7'b0110110;
        logic [6:0] exp_out = 7'b0001000;
        load_cfg(8'b0000_0110, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (match_cnt !== 2'd0 || armed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL novl_load got cnt=%0d armed=%b want cnt=0 armed=0", match_cnt, armed);
        end
        for (int i = 0; i < 7; i++) begin
            put_bit(1'b1, stream[6-i]);
            checks++;
            if (out !== exp_out[6-i]) begin
                errors++;
                $display("[TB] FAIL novl_out bit%0d got=%b want=%b", i + 1, out, exp_out[6-i]);
            end
            checks++;
            if (armed !== 1'b0) begin
                errors++;
                $display("[TB] FAIL novl_armed bit%0d got=%b want=0", i + 1, armed);
            end
        end
        checks++;
        if (match_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL novl_cnt got=%0d want=1", match_cnt);
        end
    endtask

    task automatic test_gapped_valid();
        logic [3:0] stream = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put_bit(1'b1, stream[3-i]);
            checks++;
            if (out !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL gap_out bit%0d got=%b want=%b", i + 1, out, (i == 3));
            end
            for (int g = 0; g < 2; g++) begin
                put_bit(1'b0, 1'b1);
                checks++;
                if (out !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap_idle bit%0d idle%0d got=%b want=0", i + 1, g, out);
                end
            end
        end
        checks++;
        if (match_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL gap_cnt got=%0d want=1", match_cnt);
        end
    endtask

    task automatic test_reload_midstream();
        logic [2:0] post    = 3'b101;
        logic [2:0] exp_out = 3'b001;
        logic [2:0] exp_arm = 3'b001;
        do_reset();
        put_bit(1'b1, 1'b1);
        put_bit(1'b1, 1'b0);
        put_bit(1'b1, 1'b1);
        load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            put_bit(1'b1, post[2-i]);
            checks++;
            if (out !== exp_out[2-i]) begin
                errors++;
                $display("[TB] FAIL reload_out bit%0d got=%b want=%b", i + 1, out, exp_out[2-i]);
            end
            checks++;
            if (armed !== exp_arm[2-i]) begin
                errors++;
                $display("[TB] FAIL reload_armed bit%0d got=%b want=%b", i + 1, armed, exp_arm[2-i]);
            end
        end
        checks++;
        if (match_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL reload_cnt got=%0d want=1", match_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        load_cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            put_bit(1'b1, 1'b1);
            checks++;
            if (out !== 1'b1 || match_cnt !== exp_cnt[i]) begin
                errors++;
                $display("[TB] FAIL b2b bit%0d got out=%b cnt=%0d want out=1 cnt=%0d",
                         i + 1, out, match_cnt, exp_cnt[i]);
            end
        end
        cnt_clr = 1'b1;
        put_bit(1'b1, 1'b1);
        cnt_clr = 1'b0;
        checks++;
        if (out !== 1'b1 || match_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL b2b_clr got out=%b cnt=%0d want out=1 cnt=0", out, match_cnt);
        end
        put_bit(1'b1, 1'b1);
        checks++;
        if (match_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL b2b_after_clr got=%0d want=1", match_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        put_bit(1'b1, 1'b1);
        put_bit(1'b1, 1'b0);
        put_bit(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (match_cnt !== 2'd0 || out !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async got cnt=%0d out=%b armed=%b want 0/0/0",
                     match_cnt, out, armed);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        put_bit(1'b1, 1'b1);
        checks++;
        if (out !== 1'b0 || armed !== 1'b0 || match_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midrst_after got out=%b armed=%b cnt=%0d want 0/0/0",
                     out, armed, match_cnt);
        end
    endtask

    task automatic test_len_clamp();
        logic [7:0] stream = 8'b1010_0101;
        load_cfg(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp0_armed_load got=%b want=0", armed);
        end
        put_bit(1'b1, 1'b0);
        checks++;
        if (out !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clamp0_bit0 got out=%b armed=%b want out=0 armed=1", out, armed);
        end
        put_bit(1'b1, 1'b1);
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clamp0_bit1 got=%b want=1", out);
        end
        load_cfg(8'b1010_0101, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            put_bit(1'b1, stream[7-i]);
            checks++;
            if (out !== (i == 7) || armed !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clamp15 bit%0d got out=%b armed=%b want out=%b armed=0",
                         i + 1, out, armed, (i == 7));
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in          = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;

        test_reset();
        test_overlap_default();
        test_non_overlap();
        test_gapped_valid();
        test_reload_midstream();
        test_back_to_back();
        test_reset_midstream();
        test_len_clamp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
